// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pkg: shared definitions for the control-signal pipeline.
//   - default ALU control width and the ALU control encodings
//   - field order / bit offsets of the E, M and W control bundles
//   - bubble (all-zero) constants for the fixed-width M and W bundles
// The E bundle is {flags, alucontrol}. The flags sit directly above the
// ALU control field, so their absolute position is ALUCTL_W + E_OFS_*.
package ctrl_pkg;

    localparam int ALUCTL_W_DEF = 5;

    typedef enum logic [ALUCTL_W_DEF-1:0] {
        ALU_AND   = 5'b00000,
        ALU_OR    = 5'b00001,
        ALU_ADD   = 5'b00010,
        ALU_SUB   = 5'b00110,
        ALU_SLT   = 5'b00111,
        ALU_MULT  = 5'b01000,
        ALU_MULTU = 5'b01001,
        ALU_DIV   = 5'b01010,
        ALU_DIVU  = 5'b01011
    } aluOp_e;

    // E bundle flag offsets, counted from the bit just above alucontrol.
    localparam int E_FLAGS        = 6;
    localparam int E_OFS_MDU      = 0;
    localparam int E_OFS_REGWRITE = 1;
    localparam int E_OFS_REGDST   = 2;
    localparam int E_OFS_ALUSRC   = 3;
    localparam int E_OFS_MEMWRITE = 4;
    localparam int E_OFS_MEMTOREG = 5;

    // M bundle: {memtoreg, memwrite, regwrite, exc}
    localparam int M_W            = 4;
    localparam int M_OFS_EXC      = 0;
    localparam int M_OFS_REGWRITE = 1;
    localparam int M_OFS_MEMWRITE = 2;
    localparam int M_OFS_MEMTOREG = 3;

    // W bundle: {memtoreg, regwrite}
    localparam int W_W            = 2;
    localparam int W_OFS_REGWRITE = 0;
    localparam int W_OFS_MEMTOREG = 1;

    localparam logic [M_W-1:0] BUBBLE_M = '0;
    localparam logic [W_W-1:0] BUBBLE_W = '0;

    // Total E bundle width for a given ALU control width.
    function automatic int eBundleW(input int aluctlW);
        return aluctlW + E_FLAGS;
    endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: control-path signals between the decoders / hazard unit
// (master side) and the control pipeline (slave side).
//   D-stage decoded bits, flushE, overflowE   : master -> slave
//   E/M/W control bits, mdu_startE, mdu_stall : slave -> master
interface ctrl_pipe_if #(
    parameter int ALUCTL_W = ctrl_pkg::ALUCTL_W_DEF
) ();
    // D-stage decoded control
    logic                regwriteD;
    logic                regdstD;
    logic                alusrcD;
    logic                memwriteD;
    logic                memtoregD;
    logic                mduD;
    logic [ALUCTL_W-1:0] alucontrolD;
    // hazard / datapath feedback
    logic                flushE;
    logic                overflowE;
    // E stage
    logic                memtoregE;
    logic                alusrcE;
    logic                regdstE;
    logic                regwriteE;
    logic                mduE;
    logic [ALUCTL_W-1:0] alucontrolE;
    logic                mdu_startE;
    logic                mdu_stall;
    // M stage
    logic                memtoregM;
    logic                memwriteM;
    logic                regwriteM;
    logic                excM;
    // W stage
    logic                memtoregW;
    logic                regwriteW;

    modport master (
        output regwriteD, regdstD, alusrcD, memwriteD, memtoregD, mduD,
               alucontrolD, flushE, overflowE,
        input  memtoregE, alusrcE, regdstE, regwriteE, mduE, alucontrolE,
               mdu_startE, mdu_stall, memtoregM, memwriteM, regwriteM, excM,
               memtoregW, regwriteW
    );

    modport slave (
        input  regwriteD, regdstD, alusrcD, memwriteD, memtoregD, mduD,
               alucontrolD, flushE, overflowE,
        output memtoregE, alusrcE, regdstE, regwriteE, mduE, alucontrolE,
               mdu_startE, mdu_stall, memtoregM, memwriteM, regwriteM, excM,
               memtoregW, regwriteW
    );
endinterface

// File: rtl/ctrl_pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline register.
//   clk, rst : clock, synchronous active-high reset
//   en       : load d
//   clr      : load all zeros (bubble)
//   d, q     : WIDTH-bit data in / out
// Priority: rst > clr > en; with none asserted the register holds.
module pipe_stage_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] qReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            qReg <= '0;
        end else if (clr) begin
            qReg <= '0;
        end else if (en) begin
            qReg <= d;
        end
    end

    assign q = qReg;
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: decoded-control pipeline D -> E -> M -> W for the 5-stage core.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : ctrl_pipe_if slave port (D inputs, flushE, overflowE in;
//               E/M/W control, mdu_startE, mdu_stall out)
// Parameters:
//   ALUCTL_W  : ALU control width (must match the interface instance)
//   MDU_LAT   : cycles an MDU op occupies E (>=1, 1 = no hold)
// An MDU op holds E for MDU_LAT cycles; during the first MDU_LAT-1 of them
// mdu_stall freezes the front end and M receives bubbles. Overflow in E
// suppresses the register/memory write of that instruction and raises excM.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int ALUCTL_W = ALUCTL_W_DEF,
    parameter int MDU_LAT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    ctrl_pipe_if.slave  bus
);
    localparam int E_W      = eBundleW(ALUCTL_W);
    // A single-cycle MDU still needs a 1-bit counter to keep the logic legal.
    localparam int CNT_W    = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

    // ---------------- E stage ----------------
    logic [E_FLAGS-1:0] flagsD;
    logic [E_W-1:0]     eNext;
    logic [E_W-1:0]     eQ;
    logic               mduStall;
    logic               enE;
    logic               clrE;
    logic               loadMduE;

    assign flagsD[E_OFS_MDU]      = bus.mduD;
    assign flagsD[E_OFS_REGWRITE] = bus.regwriteD;
    assign flagsD[E_OFS_REGDST]   = bus.regdstD;
    assign flagsD[E_OFS_ALUSRC]   = bus.alusrcD;
    assign flagsD[E_OFS_MEMWRITE] = bus.memwriteD;
    assign flagsD[E_OFS_MEMTOREG] = bus.memtoregD;
    assign eNext = {flagsD, bus.alucontrolD};

    // A hold outranks a flush: the instruction occupying E must not be lost.
    assign enE      = ~mduStall;
    assign clrE     = bus.flushE & ~mduStall;
    assign loadMduE = enE & ~bus.flushE & bus.mduD;

    pipe_stage_reg #(.WIDTH(E_W)) eStage (
        .clk (clk),
        .rst (rst),
        .en  (enE),
        .clr (clrE),
        .d   (eNext),
        .q   (eQ)
    );

    // ---------------- MDU hold counter ----------------
    logic [CNT_W-1:0] cntReg;
    logic [CNT_W-1:0] cntNext;
    logic             startReg;

    always_comb begin
        cntNext = '0;
        if (mduStall) begin
            cntNext = cntReg - CNT_W'(1);
        end else if (loadMduE) begin
            cntNext = CNT_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cntReg   <= '0;
            startReg <= 1'b0;
        end else begin
            cntReg   <= cntNext;
            startReg <= loadMduE;
        end
    end

    // Purely from registered state, so no D-stage input reaches mdu_stall.
    assign mduStall = eQ[ALUCTL_W + E_OFS_MDU] & (cntReg != '0);

    // ---------------- M stage ----------------
    logic [M_W-1:0] mNext;
    logic [M_W-1:0] mQ;
    logic           regwriteE;
    logic           ovfE;

    assign regwriteE = eQ[ALUCTL_W + E_OFS_REGWRITE];
    assign ovfE      = bus.overflowE;

    // During a hold M is cleared, so overflow seen in hold cycles is dropped.
    assign mNext[M_OFS_MEMTOREG] = eQ[ALUCTL_W + E_OFS_MEMTOREG];
    assign mNext[M_OFS_MEMWRITE] = eQ[ALUCTL_W + E_OFS_MEMWRITE] & ~ovfE;
    assign mNext[M_OFS_REGWRITE] = regwriteE & ~ovfE;
    assign mNext[M_OFS_EXC]      = regwriteE & ovfE;

    pipe_stage_reg #(.WIDTH(M_W)) mStage (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .clr (mduStall),
        .d   (mNext),
        .q   (mQ)
    );

    // ---------------- W stage ----------------
    logic [W_W-1:0] wNext;
    logic [W_W-1:0] wQ;

    assign wNext[W_OFS_MEMTOREG] = mQ[M_OFS_MEMTOREG];
    assign wNext[W_OFS_REGWRITE] = mQ[M_OFS_REGWRITE];

    pipe_stage_reg #(.WIDTH(W_W)) wStage (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .clr (1'b0),
        .d   (wNext),
        .q   (wQ)
    );

    // ---------------- outputs ----------------
    assign bus.alucontrolE = eQ[ALUCTL_W-1:0];
    assign bus.mduE        = eQ[ALUCTL_W + E_OFS_MDU];
    assign bus.regwriteE   = regwriteE;
    assign bus.regdstE     = eQ[ALUCTL_W + E_OFS_REGDST];
    assign bus.alusrcE     = eQ[ALUCTL_W + E_OFS_ALUSRC];
    assign bus.memtoregE   = eQ[ALUCTL_W + E_OFS_MEMTOREG];
    assign bus.mdu_startE  = startReg;
    assign bus.mdu_stall   = mduStall;

    assign bus.memtoregM   = mQ[M_OFS_MEMTOREG];
    assign bus.memwriteM   = mQ[M_OFS_MEMWRITE];
    assign bus.regwriteM   = mQ[M_OFS_REGWRITE];
    assign bus.excM        = mQ[M_OFS_EXC];

    assign bus.memtoregW   = wQ[W_OFS_MEMTOREG];
    assign bus.regwriteW   = wQ[W_OFS_REGWRITE];
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: drives two builds of ctrl_pipe (MDU_LAT=4 and MDU_LAT=1)
// with the same stimulus and compares every cycle against an
// instruction-level reference model: each instruction remembers how many
// cycles it has spent in E and leaves once it has used its latency.
module tb_ctrl_pipe;
    import ctrl_pkg::*;

    localparam int AW = 5;

    typedef struct packed {
        logic          memtoreg;
        logic          memwrite;
        logic          alusrc;
        logic          regdst;
        logic          regwrite;
        logic          mdu;
        logic [AW-1:0] aluc;
    } instr_t;

    typedef struct packed {
        logic memtoreg;
        logic memwrite;
        logic regwrite;
        logic exc;
    } mSlot_t;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } wSlot_t;

    logic clk;
    logic rst;

    ctrl_pipe_if #(.ALUCTL_W(AW)) bus4 ();
    ctrl_pipe_if #(.ALUCTL_W(AW)) bus1 ();

    ctrl_pipe #(.ALUCTL_W(AW), .MDU_LAT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    ctrl_pipe #(.ALUCTL_W(AW), .MDU_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;
    int cycle     = 0;

    // reference model state, index 0 = MDU_LAT 4 build, 1 = MDU_LAT 1 build
    int     lat [2] = '{4, 1};
    instr_t eS  [2];
    int     eAge[2];
    mSlot_t mS  [2];
    wSlot_t wS  [2];

    int stallSeen[2];
    int startSeen[2];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cycle, obs, exp);
        end
    endtask

    function automatic logic modelStall(input int k);
        return eS[k].mdu && (eAge[k] + 1 < lat[k]);
    endfunction

    function automatic logic modelStart(input int k);
        return eS[k].mdu && (eAge[k] == 0);
    endfunction

    function automatic logic [31:0] expE(input int k);
        return {22'b0, eS[k].memtoreg, eS[k].alusrc, eS[k].regdst,
                eS[k].regwrite, eS[k].mdu, eS[k].aluc};
    endfunction

    function automatic logic [31:0] expMW(input int k);
        return {26'b0, mS[k].memtoreg, mS[k].memwrite, mS[k].regwrite,
                mS[k].exc, wS[k].memtoreg, wS[k].regwrite};
    endfunction

    function automatic logic [31:0] expHs(input int k);
        return {30'b0, modelStall(k), modelStart(k)};
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            eS[k] = '0; eAge[k] = 0; mS[k] = '0; wS[k] = '0;
        end
    endtask

    task automatic modelStep(input logic r, input instr_t d, input logic fl, input logic ov);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                eS[k] = '0; eAge[k] = 0; mS[k] = '0; wS[k] = '0;
            end else begin
                wS[k].memtoreg = mS[k].memtoreg;
                wS[k].regwrite = mS[k].regwrite;
                if (modelStall(k)) begin
                    mS[k] = '0;
                    eAge[k] = eAge[k] + 1;
                end else begin
                    mS[k].memtoreg = eS[k].memtoreg;
                    mS[k].memwrite = eS[k].memwrite & ~ov;
                    mS[k].regwrite = eS[k].regwrite & ~ov;
                    mS[k].exc      = eS[k].regwrite & ov;
                    eS[k]   = fl ? instr_t'('0) : d;
                    eAge[k] = 0;
                end
            end
        end
    endtask

    task automatic compareAll();
        logic [31:0] oE [2];
        logic [31:0] oMW[2];
        logic [31:0] oHs[2];
        oE[0]  = {22'b0, bus4.memtoregE, bus4.alusrcE, bus4.regdstE,
                  bus4.regwriteE, bus4.mduE, bus4.alucontrolE};
        oE[1]  = {22'b0, bus1.memtoregE, bus1.alusrcE, bus1.regdstE,
                  bus1.regwriteE, bus1.mduE, bus1.alucontrolE};
        oMW[0] = {26'b0, bus4.memtoregM, bus4.memwriteM, bus4.regwriteM,
                  bus4.excM, bus4.memtoregW, bus4.regwriteW};
        oMW[1] = {26'b0, bus1.memtoregM, bus1.memwriteM, bus1.regwriteM,
                  bus1.excM, bus1.memtoregW, bus1.regwriteW};
        oHs[0] = {30'b0, bus4.mdu_stall, bus4.mdu_startE};
        oHs[1] = {30'b0, bus1.mdu_stall, bus1.mdu_startE};
        $display("[TB] cyc %0d rst=%0d | L4 E=%h MW=%h hs=%h | L1 E=%h MW=%h hs=%h",
                 cycle, rst, oE[0][9:0], oMW[0][5:0], oHs[0][1:0],
                 oE[1][9:0], oMW[1][5:0], oHs[1][1:0]);
        checkVal("lat4_E",  oE[0],  expE(0));
        checkVal("lat4_MW", oMW[0], expMW(0));
        checkVal("lat4_hs", oHs[0], expHs(0));
        checkVal("lat1_E",  oE[1],  expE(1));
        checkVal("lat1_MW", oMW[1], expMW(1));
        checkVal("lat1_hs", oHs[1], expHs(1));
        for (int k = 0; k < 2; k++) begin
            stallSeen[k] += int'(oHs[k][1]);
            startSeen[k] += int'(oHs[k][0]);
        end
    endtask

    task automatic driveBus(input instr_t d, input logic fl, input logic ov);
        bus4.regwriteD = d.regwrite; bus1.regwriteD = d.regwrite;
        bus4.regdstD   = d.regdst;   bus1.regdstD   = d.regdst;
        bus4.alusrcD   = d.alusrc;   bus1.alusrcD   = d.alusrc;
        bus4.memwriteD = d.memwrite; bus1.memwriteD = d.memwrite;
        bus4.memtoregD = d.memtoreg; bus1.memtoregD = d.memtoreg;
        bus4.mduD      = d.mdu;      bus1.mduD      = d.mdu;
        bus4.alucontrolD = d.aluc;   bus1.alucontrolD = d.aluc;
        bus4.flushE    = fl;         bus1.flushE    = fl;
        bus4.overflowE = ov;         bus1.overflowE = ov;
    endtask

    // Check the current state, apply one cycle of inputs, advance the model.
    task automatic runCycle(input logic r, input instr_t d, input logic fl, input logic ov);
        @(negedge clk);
        compareAll();
        rst = r;
        driveBus(d, fl, ov);
        @(posedge clk);
        modelStep(r, d, fl, ov);
        cycle++;
    endtask

    function automatic instr_t randInstr();
        instr_t d;
        d.memtoreg = 1'($urandom_range(0, 1));
        d.memwrite = 1'($urandom_range(0, 1));
        d.alusrc   = 1'($urandom_range(0, 1));
        d.regdst   = 1'($urandom_range(0, 1));
        d.regwrite = 1'($urandom_range(0, 1));
        d.mdu      = ($urandom_range(0, 2) == 0);
        d.aluc     = AW'($urandom);
        return d;
    endfunction

    initial begin
        instr_t zero;
        instr_t mult;
        zero = '0;
        mult = '0;
        mult.mdu  = 1'b1;
        mult.aluc = ALU_MULT;
        rst = 1'b1;
        driveBus(zero, 1'b0, 1'b0);
        modelReset();
        stallSeen = '{0, 0};
        startSeen = '{0, 0};

        // Reset with random D inputs, then idle with all-zero inputs.
        runCycle(1'b1, randInstr(), 1'b0, 1'b0);
        runCycle(1'b1, randInstr(), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) runCycle(1'b0, zero, 1'b0, 1'b0);

        // Single mult: count stall and start pulses seen on each build.
        stallSeen = '{0, 0};
        startSeen = '{0, 0};
        runCycle(1'b0, mult, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) runCycle(1'b0, zero, 1'b0, 1'b0);
        checkVal("lat4_stall_cycles", 32'(stallSeen[0]), 32'd3);
        checkVal("lat4_start_pulses", 32'(startSeen[0]), 32'd1);
        checkVal("lat1_stall_cycles", 32'(stallSeen[1]), 32'd0);
        checkVal("lat1_start_pulses", 32'(startSeen[1]), 32'd1);

        // Randomised traffic: flushes, overflows, MDU ops and rare resets.
        for (int i = 0; i < 600; i++) begin
            runCycle(($urandom_range(0, 49) == 0), randInstr(),
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
        end
        @(negedge clk);
        compareAll();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised control-signal pipeline for the 5-stage MIPS core. It carries decoded control bits from D through E, M and W, with E-stage bubble insertion (flush) and per-instruction overflow suppression. It adds a multi-cycle MDU (mult/div) hold in E that stalls the front end and injects bubbles into M. The block sits between the main/ALU decoders and the datapath, and replaces the fixed-width single-cycle controller pipeline.

## Interface
- `ALUCTL_W`, default 5: width of the ALU control field.
- `MDU_LAT`, default 4: total cycles an MDU instruction occupies E. Must be ≥1; a value of 1 means no hold.
- `clk`  in  1  core clock.
- `rst`  in  1  reset, synchronous and active-high. The sole clock is `clk`.
- `regwriteD, regdstD, alusrcD, memwriteD, memtoregD, mduD`  in  1 each  decoded control bits for the D-stage instruction.
- `alucontrolD`  in  `ALUCTL_W`  decoded ALU operation.
- `flushE`  in  1  hazard-unit request to load a bubble into E.
- `overflowE`  in  1  ALU signed overflow for the instruction in E.
- `memtoregE, alusrcE, regdstE, regwriteE, mduE`  out  1 each  E-stage control bits.
- `alucontrolE`  out  `ALUCTL_W`  E-stage ALU operation.
- `mdu_startE`  out  1  one-cycle pulse in the first cycle an MDU instruction is in E.
- `mdu_stall`  out  1  E is holding; the hazard unit freezes F and D.
- `memtoregM, memwriteM, regwriteM`  out  1 each  M-stage control bits.
- `excM`  out  1  the M-stage instruction overflowed.
- `memtoregW, regwriteW`  out  1 each  W-stage control bits.

## Operation
- **E register**
  - Holds the bundle {memtoreg, memwrite, alusrc, regdst, regwrite, mdu, alucontrol}.
  - Priority, highest first: `rst` → all 0; `mdu_stall` → hold; `flushE` → all 0; otherwise load the D bundle.
  - `flushE` is ignored while `mdu_stall`=1.
- **MDU counter** `cnt`, width clog2(`MDU_LAT`):
  - Loads `MDU_LAT`-1 when E loads a bundle with mdu=1.
  - Decrements while non-zero.
  - Is forced to 0 by flush or by a non-MDU load.
- **MDU outputs**
  - `mdu_stall` = `mduE` & (`cnt`≠0). This is combinational from registered state and has no path from D-stage inputs.
  - `mdu_startE` = registered flag set on the cycle E loads an MDU bundle, cleared otherwise. It is high for exactly one cycle per MDU instruction, including when `MDU_LAT`=1.
- **M register**
  - Loads all zeros (bubble) in every cycle `mdu_stall`=1.
  - Otherwise loads memtoreg, memwrite & ~`overflowE`, regwrite & ~`overflowE`, and `excM` = `overflowE` & `regwriteE`.
- **Overflow sampling:** `overflowE` is sampled only in cycles where E advances. Overflow during hold cycles is ignored.
- **W register:** loads {`memtoregM`, `regwriteM`} unconditionally.
- **Reset value:** every registered output and `cnt` are 0. Therefore `mdu_stall`, `mdu_startE` and `excM` are 0 after reset.

## Timing
- D→E, E→M and M→W are one cycle each; a non-MDU instruction reaches W 3 cycles after D.
- An MDU instruction stays in E for `MDU_LAT` cycles and reaches M on cycle `MDU_LAT` after entering E.
- `mdu_stall` is high for `MDU_LAT`-1 cycles, starting in the cycle the instruction enters E. M receives `MDU_LAT`-1 bubbles.
- Back-to-back MDU ops: the second op loads in the cycle after the first op's last E cycle; `cnt` reloads with no gap.
- `rst` asserted mid-hold: on the next edge all stages are zero and `mdu_stall`=0. The held instruction is discarded.
- A flush arriving in the final hold cycle (`cnt`=0) is honoured: E becomes a bubble on the next edge.

## Structure
- Shared package `ctrl_pkg` holds:
  - the ALU control width constant and the alucontrol encodings;
  - the bundle field order/offsets;
  - the bubble (all-zero) constant.
- One sub-module, `pipe_stage_reg`:
  - parameter WIDTH; inputs en, clr;
  - synchronous `rst` > clr > en priority.
- Instantiated three times, for E, M and W. The counter and the overflow/bubble muxing live in `ctrl_pipe`.

## Test plan
- **Reset:** assert `rst` 2 cycles with random D inputs → all outputs 0. With `rst` low and all D inputs 0, outputs stay 0.
- **add through the pipe:** D = regwrite=1, regdst=1, alucontrol=5'b00010 → appears on E at t+1, `regwriteM`=1 at t+2, `regwriteW`=1 at t+3; `mdu_stall` stays 0.
- **flushE:** D = lw (memtoreg=1, regwrite=1, alusrc=1) with `flushE`=1 → E all 0 next cycle; M and W are bubbles on the following cycles.
- **MDU, `MDU_LAT`=4:** mult (mduD=1) →
  - `mdu_startE`=1 for 1 cycle;
  - `mdu_stall`=1 for 3 cycles;
  - M shows 3 bubbles, then mult control bits.
  - `flushE` pulsed mid-hold has no effect.
  - `rst` pulsed mid-hold (separate run) → `mdu_stall`=0 next cycle.
- **Overflow:** add with regwriteE=1 and `overflowE`=1 → next cycle `regwriteM`=0, `memwriteM`=0, `excM`=1. The following add (no overflow) gives `regwriteM`=1, `excM`=0.
- **`MDU_LAT`=1 build:** mult → `mdu_startE` pulses, `mdu_stall` never rises, and the op reaches M on the next cycle.
